// File: rtl/mips_pkg.sv
// Shared definitions for the ID-stage stall/flush controller: FSM encoding,
// register-zero constant, counter widths and a saturating increment helper.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } stall_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 2;
    localparam int         PERF_CNT_W  = 32;

    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;
    typedef logic [PERF_CNT_W-1:0]  perf_cnt_t;

    function automatic perf_cnt_t sat_inc(input perf_cnt_t v);
        return (&v) ? v : v + perf_cnt_t'(1);
    endfunction

endpackage

// File: rtl/hazard_compare.sv
// Combinational load-use / branch-operand hazard detector; reports how many
// bubble cycles the instruction in ID needs before it may advance.
module hazard_compare
    import mips_pkg::*;
(
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       id_uses_rt,
    input  logic       id_is_branch,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_reg_write,
    input  logic       id_ex_mem_read,
    input  logic [4:0] ex_m_rd,
    input  logic       ex_m_mem_read,
    output logic [1:0] need
);

    logic ex_hit;
    logic m_hit;

    // $zero never carries a real dependency.
    assign ex_hit = (id_ex_rd != REG_ZERO) &&
                    ((id_ex_rd == if_id_rs) || (id_uses_rt && (id_ex_rd == if_id_rt)));
    assign m_hit  = (ex_m_rd != REG_ZERO) &&
                    ((ex_m_rd == if_id_rs) || (id_uses_rt && (ex_m_rd == if_id_rt)));

    always_comb begin
        need = 2'd0;
        if (id_is_branch && id_ex_mem_read && ex_hit)
            need = 2'd2;
        else if (id_ex_mem_read && ex_hit)
            need = 2'd1;
        else if (id_is_branch && id_ex_reg_write && ex_hit)
            need = 2'd1;
        else if (id_is_branch && ex_m_mem_read && m_hit)
            need = 2'd1;
    end

endmodule

// File: rtl/id_stall_controller.sv
// ID-stage stall controller: RUN/STALL/HALT FSM driving PC/IF-ID enables, ID/EX
// bubble and IF-ID flush. Define HAZARD_PERF_CNT_EN for stall/flush perf counters.
module id_stall_controller
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        id_uses_rt,
    input  logic        id_is_branch,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_reg_write,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  ex_m_rd,
    input  logic        ex_m_mem_read,
    input  logic        branch_taken,
    input  logic        halt,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    logic [1:0]   need;
    stall_state_e state;
    stall_cnt_t   cnt;
    logic         pc_w_core, ifid_w_core, bubble_core, flush_core;

    hazard_compare u_cmp (
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_is_branch    (id_is_branch),
        .id_ex_rd        (id_ex_rd),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_m_rd         (ex_m_rd),
        .ex_m_mem_read   (ex_m_mem_read),
        .need            (need)
    );

    // Controls must react in the same cycle as the hazard, so they are decoded
    // from state + inputs rather than registered.
    always_comb begin
        pc_w_core   = 1'b0;
        ifid_w_core = 1'b0;
        bubble_core = 1'b0;
        flush_core  = 1'b0;
        if (!halt) begin
            case (state)
                ST_RUN: begin
                    if (need != 2'd0) begin
                        bubble_core = 1'b1;
                    end else begin
                        pc_w_core   = 1'b1;
                        ifid_w_core = 1'b1;
                        flush_core  = branch_taken;
                    end
                end
                ST_STALL: bubble_core = 1'b1;
                default:  ;
            endcase
        end
    end

    assign pc_write     = rst_n & pc_w_core;
    assign if_id_write  = rst_n & ifid_w_core;
    assign id_ex_bubble = rst_n & bubble_core;
    assign if_id_flush  = rst_n & flush_core;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else if (halt) begin
            state <= ST_HALT;
        end else begin
            case (state)
                ST_RUN: begin
                    if (need == 2'd2) begin
                        state <= ST_STALL;
                        cnt   <= need - 2'd1;
                    end
                end
                ST_STALL: begin
                    if (cnt <= stall_cnt_t'(1)) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - stall_cnt_t'(1);
                    end
                end
                ST_HALT: state <= (cnt != '0) ? ST_STALL : ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    perf_cnt_t stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (bubble_core) stall_q <= sat_inc(stall_q);
            if (flush_core)  flush_q <= sat_inc(flush_q);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_id_stall_controller.sv
// Bench for id_stall_controller: vector table, directed multi-cycle sequences,
// and randomized traffic against a cycle-level reference model.
module tb_id_stall_controller;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  if_id_rs, if_id_rt, id_ex_rd, ex_m_rd;
    logic        id_uses_rt, id_is_branch, id_ex_reg_write, id_ex_mem_read;
    logic        ex_m_mem_read, branch_taken, halt;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic [31:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stall_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_is_branch    (id_is_branch),
        .id_ex_rd        (id_ex_rd),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_m_rd         (ex_m_rd),
        .ex_m_mem_read   (ex_m_mem_read),
        .branch_taken    (branch_taken),
        .halt            (halt),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       uses_rt, br;
        logic [4:0] ex_rd;
        logic       ex_rw, ex_mr;
        logic [4:0] m_rd;
        logic       m_mr, taken, hlt;
        logic [3:0] exp;   // {pc_write, if_id_write, id_ex_bubble, if_id_flush}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic br, input logic [4:0] exrd,
                       input logic exrw, input logic exmr, input logic [4:0] mrd,
                       input logic mmr, input logic tk, input logic h, input logic [3:0] e);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.br = br;
        v.ex_rd = exrd; v.ex_rw = exrw; v.ex_mr = exmr; v.m_rd = mrd;
        v.m_mr = mmr; v.taken = tk; v.hlt = h; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] exp);
        chk(name, {28'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush}, {28'd0, exp});
    endtask

    task automatic chk_cnt(input string name, input int sc, input int fc);
        chk({name, "_stall_cycles"}, stall_cycles, PERF ? sc : 0);
        chk({name, "_flush_count"},  flush_count,  PERF ? fc : 0);
    endtask

    task automatic idle();
        if_id_rs = 0; if_id_rt = 0; id_uses_rt = 0; id_is_branch = 0;
        id_ex_rd = 0; id_ex_reg_write = 0; id_ex_mem_read = 0;
        ex_m_rd = 0; ex_m_mem_read = 0; branch_taken = 0; halt = 0;
    endtask

    task automatic apply(input vec_t v);
        if_id_rs = v.rs; if_id_rt = v.rt; id_uses_rt = v.uses_rt; id_is_branch = v.br;
        id_ex_rd = v.ex_rd; id_ex_reg_write = v.ex_rw; id_ex_mem_read = v.ex_mr;
        ex_m_rd = v.m_rd; ex_m_mem_read = v.m_mr; branch_taken = v.taken; halt = v.hlt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Bubble cycles the ID instruction needs, straight from the hazard rules.
    function automatic int need_model();
        bit hit_ex, hit_m;
        hit_ex = (id_ex_rd != 0) && (id_ex_rd == if_id_rs || (id_uses_rt && id_ex_rd == if_id_rt));
        hit_m  = (ex_m_rd  != 0) && (ex_m_rd  == if_id_rs || (id_uses_rt && ex_m_rd  == if_id_rt));
        if (id_is_branch && id_ex_mem_read && hit_ex)  return 2;
        if (id_ex_mem_read && hit_ex)                  return 1;
        if (id_is_branch && id_ex_reg_write && hit_ex) return 1;
        if (id_is_branch && ex_m_mem_read && hit_m)    return 1;
        return 0;
    endfunction

    initial begin
        int owed, nd;
        bit halted;
        longint msc, mfc;
        logic [3:0] e;

        idle();
        #2;
        chk_out("reset_outputs", 4'b0000);
        chk("reset_stall_cycles", stall_cycles, 0);
        chk("reset_flush_count", flush_count, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_out("run_after_release", 4'b1100);
        tick();

        //   name            rs rt ur br exrd rw mr mrd mmr tk h  exp
        add("lw_use",         5, 0, 0, 0, 5,  1, 1, 0,  0,  0, 0, 4'b0010);
        add("lw_beq",         7, 0, 0, 1, 7,  1, 1, 0,  0,  0, 0, 4'b0010);
        add("alu_beq_rt",     1, 3, 1, 1, 3,  1, 0, 0,  0,  0, 0, 4'b0010);
        add("alu_beq_rd0",    1, 3, 1, 1, 0,  1, 0, 0,  0,  0, 0, 4'b1100);
        add("zero_reg",       0, 0, 1, 1, 0,  1, 1, 0,  1,  0, 0, 4'b1100);
        add("taken_flush",    1, 2, 1, 1, 3,  1, 1, 4,  1,  1, 0, 4'b1101);
        add("rt_unused",      1, 6, 0, 0, 6,  1, 1, 0,  0,  0, 0, 4'b1100);
        add("rt_used_lw",     1, 6, 1, 0, 6,  1, 1, 0,  0,  0, 0, 4'b0010);
        add("mem_lw_beq",     4, 0, 0, 1, 9,  1, 0, 4,  1,  0, 0, 4'b0010);
        add("mem_lw_alu",     4, 0, 0, 0, 9,  1, 0, 4,  1,  0, 0, 4'b1100);
        add("alu_fwd",        8, 0, 0, 0, 8,  1, 0, 0,  0,  0, 0, 4'b1100);
        add("halt_wins",      5, 0, 0, 1, 5,  1, 1, 0,  0,  1, 1, 4'b0000);
        add("stall_no_flush", 5, 0, 0, 0, 5,  1, 1, 0,  0,  1, 0, 4'b0010);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            chk_out(vecs[i].name, vecs[i].exp);
            tick();
            idle();
            tick();
            tick();
        end

        // lw $7 then beq on $7: exactly two stall cycles, then RUN.
        pulse_reset();
        chk_cnt("cnt_after_reset", 0, 0);
        if_id_rs = 7; id_is_branch = 1; id_ex_rd = 7; id_ex_mem_read = 1; id_ex_reg_write = 1;
        #1;
        chk_out("lw_beq_stall1", 4'b0010);
        tick();
        chk_out("lw_beq_stall2", 4'b0010);
        tick();
        idle();
        #1;
        chk_out("lw_beq_resume", 4'b1100);
        chk_cnt("lw_beq_cnt", 2, 0);

        branch_taken = 1;
        #1;
        chk_out("flush_one", 4'b1101);
        tick();
        branch_taken = 0;
        #1;
        chk_out("flush_done", 4'b1100);
        chk_cnt("flush_cnt", 2, 1);

        // halt while STALL holds one pending cycle.
        if_id_rs = 7; id_is_branch = 1; id_ex_rd = 7; id_ex_mem_read = 1;
        #1;
        chk_out("halt_seq_stall", 4'b0010);
        tick();
        halt = 1;
        #1;
        chk_out("halt_in_stall", 4'b0000);
        tick();
        #1;
        chk_out("halt_held", 4'b0000);
        tick();
        idle();
        #1;
        chk_out("halt_release_cycle", 4'b0000);
        tick();
        branch_taken = 1;
        #1;
        chk_out("post_halt_stall", 4'b0010);
        tick();
        branch_taken = 0;
        #1;
        chk_out("post_halt_run", 4'b1100);
        chk_cnt("halt_seq_cnt", 4, 1);
        tick();

        // Reset in the middle of a stall.
        if_id_rs = 7; id_is_branch = 1; id_ex_rd = 7; id_ex_mem_read = 1;
        #1;
        tick();
        chk_out("pre_reset_stall", 4'b0010);
        rst_n = 1'b0;
        #1;
        chk_out("reset_mid_stall", 4'b0000);
        chk("reset_mid_stall_sc", stall_cycles, 0);
        idle();
        rst_n = 1'b1;
        #1;
        chk_out("no_residual_stall", 4'b1100);
        tick();
        chk_out("no_residual_stall2", 4'b1100);

        // Randomized traffic against the reference model.
        pulse_reset();
        owed = 0; halted = 0; msc = 0; mfc = 0;
        for (int n = 0; n < 3000; n++) begin
            if_id_rs        = 5'($urandom_range(0, 3));
            if_id_rt        = 5'($urandom_range(0, 3));
            id_ex_rd        = 5'($urandom_range(0, 3));
            ex_m_rd         = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom);
            id_is_branch    = 1'($urandom);
            id_ex_reg_write = 1'($urandom);
            id_ex_mem_read  = 1'($urandom);
            ex_m_mem_read   = 1'($urandom);
            branch_taken    = 1'($urandom);
            halt            = ($urandom_range(0, 9) == 0);
            #1;
            nd = need_model();
            if (halt || halted)          e = 4'b0000;
            else if (owed > 0 || nd > 0) e = 4'b0010;
            else                         e = {3'b110, branch_taken};
            chk_out("rand_outputs", e);
            chk("rand_stall_cycles", stall_cycles, PERF ? 32'(msc) : 32'd0);
            chk("rand_flush_count",  flush_count,  PERF ? 32'(mfc) : 32'd0);
            if (e[1] && msc < 64'hFFFF_FFFF) msc++;
            if (e[0] && mfc < 64'hFFFF_FFFF) mfc++;
            if (halt)          halted = 1;
            else if (halted)   halted = 0;
            else if (owed > 0) owed--;
            else if (nd == 2)  owed = 1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
